// File: rtl/bw_blob_tracker_pkg.sv
// Shared types and width helpers for the black/white blob tracker.
package bw_track_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_MIN_COUNT = 64;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_w(input int h, input int v);
        return $clog2(h * v + 1);
    endfunction

endpackage

// File: rtl/bw_blob_tracker_raster_counter.sv
// Raster x/y position of the next accepted pixel; a sof pixel is (0,0).
module raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           advance,
    input  logic           sof,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    // On sof the current pixel is (0,0) regardless of the count, so step past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (sof) begin
                x <= X_W'(1);
                y <= '0;
            end else if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/bw_blob_tracker.sv
// Per-frame dark-pixel count, bounding box and centre over a 1-bit raster stream.
module bw_blob_tracker
    import bw_track_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int MIN_COUNT = DEF_MIN_COUNT,
    parameter int X_W       = coord_w(H_ACTIVE),
    parameter int Y_W       = coord_w(V_ACTIVE),
    parameter int C_W       = count_w(H_ACTIVE, V_ACTIVE)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_sof,
    input  logic           i_valid,
    input  logic           i_bw,
    output logic           o_valid,
    output logic           o_found,
    output logic [X_W-1:0] o_min_x,
    output logic [X_W-1:0] o_max_x,
    output logic [X_W-1:0] o_center_x,
    output logic [Y_W-1:0] o_min_y,
    output logic [Y_W-1:0] o_max_y,
    output logic [Y_W-1:0] o_center_y,
    output logic [C_W-1:0] o_count,
    output state_t         dbg_state
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    state_t         state, state_next;
    logic [X_W-1:0] x, min_x, max_x;
    logic [Y_W-1:0] y, min_y, max_y;
    logic [C_W-1:0] count;
    logic           last, start, accept, found;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;

    // A pixel exists only when i_valid=1 (no back-pressure). It is taken when it
    // starts a frame (i_sof) or while a frame is being accumulated.
    assign start  = i_valid && i_sof;
    assign accept = start || (i_valid && (state == S_ACCUM));
    assign found  = (count >= C_W'(MIN_COUNT));
    assign sum_x  = {1'b0, min_x} + {1'b0, max_x};
    assign sum_y  = {1'b0, min_y} + {1'b0, max_y};
    assign dbg_state = state;

    raster_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_raster (
        .clk    (i_clk),
        .rst    (i_rst),
        .advance(accept),
        .sof    (start),
        .x      (x),
        .y      (y),
        .last   (last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_ACCUM;
            S_ACCUM: begin
                if (start)                  state_next = S_ACCUM;
                else if (i_valid && last)   state_next = S_REPORT;
            end
            S_REPORT: state_next = start ? S_ACCUM : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // A start pixel re-initialises and is itself folded in at (0,0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
            min_x <= '0;
            max_x <= '0;
            min_y <= '0;
            max_y <= '0;
        end else if (start) begin
            count <= C_W'(i_bw);
            min_x <= i_bw ? '0 : X_MAX;
            min_y <= i_bw ? '0 : Y_MAX;
            max_x <= '0;
            max_y <= '0;
        end else if (accept && i_bw) begin
            count <= count + C_W'(1);
            if (x < min_x) min_x <= x;
            if (x > max_x) max_x <= x;
            if (y < min_y) min_y <= y;
            if (y > max_y) max_y <= y;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_found    <= 1'b0;
            o_count    <= '0;
            o_min_x    <= '0;
            o_max_x    <= '0;
            o_center_x <= '0;
            o_min_y    <= '0;
            o_max_y    <= '0;
            o_center_y <= '0;
        end else begin
            o_valid <= (state == S_REPORT);
            if (state == S_REPORT) begin
                o_count <= count;
                o_found <= found;
                if (found) begin
                    o_min_x    <= min_x;
                    o_max_x    <= max_x;
                    o_center_x <= sum_x[X_W:1];
                    o_min_y    <= min_y;
                    o_max_y    <= max_y;
                    o_center_y <= sum_y[Y_W:1];
                end else begin
                    o_min_x    <= '0;
                    o_max_x    <= '0;
                    o_center_x <= '0;
                    o_min_y    <= '0;
                    o_max_y    <= '0;
                    o_center_y <= '0;
                end
            end
        end
    end

endmodule

// File: doc/bw_blob_tracker.md
Name: bw_blob_tracker

Overview:
Streaming per-frame analysis stage placed directly downstream of the grayscale/threshold stage. It consumes that stage's 1-bit black/white pixel (1 = dark pixel) in raster order and tracks position with internal x/y counters. Over each frame it accumulates a dark-pixel count and bounding box. At frame end it publishes box, centre and count with a one-cycle result strobe for the overlay/VGA control logic.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
MIN_COUNT, 64, minimum dark-pixel count for o_found=1
X_W, $clog2(H_ACTIVE), x coordinate width (10 at default)
Y_W, $clog2(V_ACTIVE), y coordinate width (9 at default)
C_W, $clog2(H_ACTIVE*V_ACTIVE+1), count width (19 at default)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous, active-high reset
i_sof  in  1  start of frame; qualified by i_valid, marks pixel (0,0)
i_valid  in  1  pixel strobe; gaps allowed
i_bw  in  1  thresholded pixel, 1 = dark
o_valid  out  1  one-cycle pulse: result outputs updated
o_found  out  1  count >= MIN_COUNT in the last reported frame
o_min_x, o_max_x, o_center_x  out  X_W  bounding box / centre x
o_min_y, o_max_y, o_center_y  out  Y_W  bounding box / centre y
o_count  out  C_W  dark pixels in the last reported frame

Behaviour:
- Interface: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset: state S_IDLE, counters and accumulators cleared, every output 0. Takes effect immediately, including mid-frame; the partial frame is discarded.
- Pixels are accepted only on cycles with i_valid=1. i_sof without i_valid is ignored.
- S_IDLE: ignore pixels until i_valid&i_sof. That pixel is (0,0): init accumulators (min=H/V max value, max=0, count=0), include the pixel, then go to S_ACCUM.
- S_ACCUM: on each accepted pixel, if i_bw=1: count+1; min_x/max_x/min_y/max_y updated by compare against the current x/y.
- Raster advance: x+1; at x=H_ACTIVE-1, x wraps to 0 and y+1.
- Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) accepted at edge N: goes to S_REPORT.
- S_REPORT (one cycle): outputs register at edge N+1 and o_valid=1 for exactly the cycle after edge N+1. State then returns to S_IDLE.
- i_valid&i_sof in S_REPORT starts the next frame directly (S_ACCUM); the report still issues.
- Result outputs:
  - o_count = count.
  - o_found = (count >= MIN_COUNT).
  - If found: bounding box as accumulated; center = (min+max)>>1, computed at full width+1 then truncated.
  - If not found: box and centre outputs are 0.
  - All outputs hold until the next report.
- i_valid&i_sof in S_ACCUM (short or broken frame): abort the frame with no report, re-init, and that pixel is (0,0).
- Pixels arriving while already in S_ACCUM after y has reached V_ACTIVE cannot occur, since the last pixel forces S_REPORT.
- Count cannot overflow: C_W holds H_ACTIVE*V_ACTIVE.

Decomposition:
- Package bw_track_pkg holds:
  - state enum {S_IDLE, S_ACCUM, S_REPORT};
  - default H_ACTIVE/V_ACTIVE constants;
  - the width helper functions.
- Sub-module raster_counter: x/y counters with an advance enable, a sync clear-to-(0,0)-then-advance on sof, and an o_last flag. The parent holds the FSM, accumulators and output registers.

Test Plan:
- Bench parameters: H_ACTIVE=16, V_ACTIVE=8, unless noted.
- Reset test: assert i_rst mid-frame. All outputs 0 asynchronously. No o_valid until a full new frame (sof to last pixel) completes.
- Single pixel: one dark pixel at (5,3), MIN_COUNT=1. Expect o_valid one cycle, 2 edges after the last pixel; count=1, found=1, box (5,3)-(5,3), centre (5,3).
- Rectangle: dark at x 2..5, y 1..3, MIN_COUNT=4, with random i_valid gaps. Expect count=12, min (2,1), max (5,3), centre (3,2).
- All-white frame: expect count=0, found=0, box/centre 0. Follow with a below-threshold frame of 3 dark pixels at MIN_COUNT=4: count=3, found=0, box 0.
- Mid-frame sof: reissue sof at pixel 40. No o_valid for the aborted frame. The next report counts only pixels after the second sof. Also test sof in the S_REPORT cycle: report still pulses and the new frame is tracked correctly.
- Corner pixels: dark at (0,0) and (15,7). Expect box (0,0)-(15,7), centre (7,3), count 2. Check that x wraps at 15 and y increments only on the wrap.
